// File: rtl/i2c_temp_target.sv
// i2c_temp_target: I2C target that serves a temperature register and a config register to an external master
module i2c_temp_target #(
  parameter logic [6:0] DEV_ADDR = 7'h4B,
  parameter int         HOLD_CYC = 8,
  parameter logic [7:0] CFG_RST  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [7:0] temp_c,
  input  logic [3:0] temp_frac,
  output logic [7:0] cfg_reg,
  output logic       busy,
  output logic       rd_done
);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP, IGNORE} state_t;
  localparam logic [7:0] HC = 8'(HOLD_CYC);
  state_t      state;
  logic [2:0]  scl_q, sda_q;
  logic [2:0]  cnt;
  logic [7:0]  sh, hcnt;
  logic [11:0] hold;
  logic        ptr, first, lsb;
  logic        scl_rise, scl_fall, start_c, stop_c, sda_s, upd;
  logic [7:0]  rx_byte;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start_c  = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_c   = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
  assign sda_s    = sda_q[1];
  assign upd      = hcnt == 8'd1;
  assign rx_byte  = {sh[6:0], sda_s};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      rd_done <= 1'b0;
      cfg_reg <= CFG_RST;
      ptr     <= 1'b0;
      cnt     <= '0;
      sh      <= '0;
      hold    <= '0;
      hcnt    <= '0;
      first   <= 1'b0;
      lsb     <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      hcnt    <= scl_fall ? HC : (hcnt != 8'd0 ? hcnt - 8'd1 : hcnt);
      if (upd) sda_oe <= (state == ADDR_ACK) | (state == RX_ACK) | ((state == TX) & ~sh[7]);
      if (stop_c) begin
        state  <= IDLE;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
      end else if (start_c) begin
        state <= ADDR;
        busy  <= 1'b1;
        cnt   <= '0;
      end else if (scl_rise) begin
        cnt <= cnt + 3'd1;
        case (state)
          ADDR: begin
            sh <= rx_byte;
            if (cnt == 3'd7) state <= (rx_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
          end
          ADDR_ACK: begin
            cnt   <= '0;
            first <= 1'b1;
            lsb   <= 1'b0;
            if (sh[0]) begin
              hold  <= {temp_c, temp_frac};
              sh    <= ptr ? cfg_reg : temp_c;
              state <= TX;
            end else state <= RX;
          end
          RX: begin
            sh <= rx_byte;
            if (cnt == 3'd7) begin
              state <= RX_ACK;
              first <= 1'b0;
              if (first) ptr <= rx_byte[0];
              else if (ptr) cfg_reg <= rx_byte;
            end
          end
          RX_ACK: begin
            cnt   <= '0;
            state <= RX;
          end
          TX: begin
            sh <= {sh[6:0], 1'b0};
            if (cnt == 3'd7) state <= TX_ACK;
          end
          TX_ACK: begin
            cnt <= '0;
            if (sda_s) state <= WAIT_STOP;
            else begin
              state <= TX;
              if (ptr) sh <= cfg_reg;
              else begin
                rd_done <= ~lsb;
                sh      <= lsb ? hold[11:4] : {hold[3:0], 4'h0};
                lsb     <= ~lsb;
              end
            end
          end
          default: ;
        endcase
      end
    end
endmodule
